// File: rtl/reg_file_2r1w.sv
// Register file: 2**ADDR_W words of DATA_W bits, one synchronous write port, two read ports.
// Optional same-cycle write forwarding, registered read outputs and a constant-zero word 0.
`timescale 1ns/1ps
module reg_file_2r1w #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 3,
  parameter int READ_REG  = 0,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG0 = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData,
  input  logic [ADDR_W-1:0] rAddr0,
  input  logic [ADDR_W-1:0] rAddr1,
  output logic [DATA_W-1:0] rData0,
  output logic [DATA_W-1:0] rData1
);
  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [NREGS];
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_raddr [2];
  logic [DATA_W-1:0] w_rdata [2];

  // A write aimed at the hard-wired zero word is dropped entirely, including forwarding.
  assign w_wr_en = we && !((ZERO_REG0 != 0) && (wAddr == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[wAddr] <= wData;
    end
  end

  assign w_raddr[0] = rAddr0;
  assign w_raddr[1] = rAddr1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [DATA_W-1:0] w_comb;

    always_comb begin
      w_comb = r_mem[w_raddr[gi]];
      if ((BYPASS != 0) && w_wr_en && (w_raddr[gi] == wAddr)) begin
        w_comb = wData;
      end
      if ((ZERO_REG0 != 0) && (w_raddr[gi] == '0)) begin
        w_comb = '0;
      end
    end

    if (READ_REG != 0) begin : g_reg
      logic [DATA_W-1:0] r_rdata;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_rdata <= '0;
        end else begin
          r_rdata <= w_comb;
        end
      end

      assign w_rdata[gi] = r_rdata;
    end else begin : g_comb
      assign w_rdata[gi] = w_comb;
    end
  end

  assign rData0 = w_rdata[0];
  assign rData1 = w_rdata[1];
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: five configurations side by side, expectations queued
// at stimulus time and popped when the corresponding output is sampled.
`timescale 1ns/1ps
module tb_reg_file_2r1w;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, we;
  logic [2:0]  wAddr, rAddr0, rAddr1;
  logic [31:0] wData;
  logic [31:0] byp_rd0, byp_rd1, nob_rd0, nob_rd1, rr_rd0, rr_rd1, z_rd0, z_rd1;
  logic        ww_we;
  logic [3:0]  ww_waddr, ww_ra0, ww_ra1;
  logic [7:0]  ww_wdata, ww_rd0, ww_rd1;

  reg_file_2r1w u_byp (.clk(clk), .reset_n(reset_n), .we(we), .wAddr(wAddr), .wData(wData),
    .rAddr0(rAddr0), .rAddr1(rAddr1), .rData0(byp_rd0), .rData1(byp_rd1));
  reg_file_2r1w #(.BYPASS(0)) u_nob (.clk(clk), .reset_n(reset_n), .we(we), .wAddr(wAddr),
    .wData(wData), .rAddr0(rAddr0), .rAddr1(rAddr1), .rData0(nob_rd0), .rData1(nob_rd1));
  reg_file_2r1w #(.READ_REG(1)) u_rr (.clk(clk), .reset_n(reset_n), .we(we), .wAddr(wAddr),
    .wData(wData), .rAddr0(rAddr0), .rAddr1(rAddr1), .rData0(rr_rd0), .rData1(rr_rd1));
  reg_file_2r1w #(.ZERO_REG0(1)) u_z (.clk(clk), .reset_n(reset_n), .we(we), .wAddr(wAddr),
    .wData(wData), .rAddr0(rAddr0), .rAddr1(rAddr1), .rData0(z_rd0), .rData1(z_rd1));
  reg_file_2r1w #(.DATA_W(8), .ADDR_W(4)) u_ww (.clk(clk), .reset_n(reset_n), .we(ww_we),
    .wAddr(ww_waddr), .wData(ww_wdata), .rAddr0(ww_ra0), .rAddr1(ww_ra1),
    .rData0(ww_rd0), .rData1(ww_rd1));

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic push(input string tag, input logic [31:0] e);
    sb_q.push_back('{tag, e});
  endtask

  task automatic check(input logic [31:0] obs);
    sb_t e;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL sb_empty observed=%h required=<none>", obs);
      $error("scoreboard empty, observed %h", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_err++;
        $display("FAIL %s observed=%h required=%h", e.tag, obs, e.exp);
        $error("%s observed %h required %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; we = 1'b0; wAddr = '0; wData = '0; rAddr0 = 3'd3; rAddr1 = 3'd5;
    ww_we = 1'b0; ww_waddr = '0; ww_wdata = '0; ww_ra0 = 4'd9; ww_ra1 = '0;

    // Reset state of every configuration
    push("rst_byp0", 32'h0); push("rst_byp1", 32'h0); push("rst_nob0", 32'h0);
    push("rst_rr1", 32'h0);  push("rst_z0", 32'h0);   push("rst_ww0", 32'h0);
    #2;
    check(byp_rd0); check(byp_rd1); check(nob_rd0); check(rr_rd1); check(z_rd0);
    check({24'h0, ww_rd0});
    #5 reset_n = 1'b1;

    // Fill all words with ones, then a short mid-cycle reset pulse clears them
    for (int i = 0; i < 8; i++) begin
      cyc(); we = 1'b1; wAddr = 3'(i); wData = 32'hFFFF_FFFF;
    end
    cyc(); we = 1'b0; rAddr0 = 3'd2; rAddr1 = 3'd6;
    push("fill_byp0", 32'hFFFF_FFFF); push("fill_byp1", 32'hFFFF_FFFF);
    push("fill_z0", 32'hFFFF_FFFF);   push("fill_nob1", 32'hFFFF_FFFF);
    @(negedge clk);
    check(byp_rd0); check(byp_rd1); check(z_rd0); check(nob_rd1);
    #0.5 reset_n = 1'b0;
    #3   reset_n = 1'b1;
    push("pulse_byp0", 32'h0); push("pulse_byp1", 32'h0); push("pulse_nob0", 32'h0);
    push("pulse_z0", 32'h0);   push("pulse_rr1", 32'h0);
    #0.5;
    check(byp_rd0); check(byp_rd1); check(nob_rd0); check(z_rd0); check(rr_rd1);
    for (int i = 0; i < 4; i++) begin
      cyc(); rAddr0 = 3'(i); rAddr1 = 3'(i + 4);
      push($sformatf("clr_p0_%0d", i), 32'h0); push($sformatf("clr_p1_%0d", i + 4), 32'h0);
      @(negedge clk);
      check(byp_rd0); check(byp_rd1);
    end

    // Write then read on both ports; a disabled write leaves the word alone
    cyc(); we = 1'b1; wAddr = 3'd3; wData = 32'h1234_1234; rAddr0 = 3'd0; rAddr1 = 3'd1;
    cyc(); we = 1'b0; wData = 32'hDEAD_BEEF; rAddr0 = 3'd3; rAddr1 = 3'd3;
    push("wr_byp0", 32'h1234_1234); push("wr_byp1", 32'h1234_1234); push("wr_nob0", 32'h1234_1234);
    @(negedge clk);
    check(byp_rd0); check(byp_rd1); check(nob_rd0);
    cyc();
    push("hold_byp0", 32'h1234_1234); push("hold_byp1", 32'h1234_1234);
    push("hold_rr1", 32'h1234_1234);
    @(negedge clk);
    check(byp_rd0); check(byp_rd1); check(rr_rd1);

    // Same-cycle forwarding versus old value
    cyc(); we = 1'b1; wAddr = 3'd5; wData = 32'h5678_5678; rAddr0 = 3'd0; rAddr1 = 3'd0;
    cyc(); wData = 32'hABCD_ABCD; rAddr0 = 3'd5; rAddr1 = 3'd4;
    push("fwd_byp0", 32'hABCD_ABCD); push("old_nob0", 32'h5678_5678); push("nofwd_byp1", 32'h0);
    @(negedge clk);
    check(byp_rd0); check(nob_rd0); check(byp_rd1);
    cyc(); we = 1'b0;
    push("after_byp0", 32'hABCD_ABCD); push("after_nob0", 32'hABCD_ABCD);
    @(negedge clk);
    check(byp_rd0); check(nob_rd0);

    // Registered read: one edge of latency, including forwarded data
    cyc(); we = 1'b1; wAddr = 3'd2; wData = 32'hDA08_712A; rAddr1 = 3'd0;
    cyc(); we = 1'b0; rAddr1 = 3'd2;
    push("rr_pre", 32'h0); push("rr_post", 32'hDA08_712A);
    @(negedge clk);
    check(rr_rd1);
    cyc();
    check(rr_rd1);
    we = 1'b1; wAddr = 3'd6; wData = 32'h0000_0066; rAddr1 = 3'd6;
    push("rr_fwd_pre", 32'hDA08_712A); push("rr_fwd_post", 32'h0000_0066);
    @(negedge clk);
    check(rr_rd1);
    cyc(); we = 1'b0;
    check(rr_rd1);

    // Hard-wired zero word
    we = 1'b1; wAddr = 3'd0; wData = 32'h0000_0001; rAddr0 = 3'd0;
    push("z_w0_fwd", 32'h0); push("byp_w0_fwd", 32'h0000_0001);
    @(negedge clk);
    check(z_rd0); check(byp_rd0);
    cyc(); we = 1'b0;
    push("z_w0", 32'h0); push("byp_w0", 32'h0000_0001);
    @(negedge clk);
    check(z_rd0); check(byp_rd0);
    cyc(); we = 1'b1; wAddr = 3'd7; wData = 32'h0000_0001; rAddr0 = 3'd7;
    push("z_w7_fwd", 32'h0000_0001);
    @(negedge clk);
    check(z_rd0);
    cyc(); we = 1'b0;
    push("z_w7", 32'h0000_0001);
    @(negedge clk);
    check(z_rd0);

    // 8-bit x 16-word configuration: distinct pattern per word, read back on both ports
    for (int i = 0; i < 16; i++) begin
      cyc(); ww_we = 1'b1; ww_waddr = 4'(i); ww_wdata = 8'(i * 17);
    end
    cyc(); ww_we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc(); ww_ra0 = 4'(i); ww_ra1 = 4'(15 - i);
      push($sformatf("ww0_%0d", i), 32'(i * 17));
      push($sformatf("ww1_%0d", 15 - i), 32'((15 - i) * 17));
      @(negedge clk);
      check({24'h0, ww_rd0}); check({24'h0, ww_rd1});
    end

    // Reset held across a write edge: the write is lost
    cyc(); we = 1'b1; wAddr = 3'd4; wData = 32'h4444_4444; rAddr0 = 3'd1; rAddr1 = 3'd4;
    #1 reset_n = 1'b0;
    cyc(); we = 1'b0; rAddr0 = 3'd4;
    #2 reset_n = 1'b1;
    push("rstw_byp0", 32'h0); push("rstw_rr1", 32'h0);
    @(negedge clk);
    check(byp_rd0); check(rr_rd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
